reel_readout: RTL

Observer for the slot machine's three reel displays. It samples the active-low 7-segment reel buses, decodes them back to BCD digits, and decides when each reel has stopped, meaning its display is unchanged for a programmable number of cycles. Once all three reels have stopped, it latches a result (digits plus match class) behind a valid/ack handshake and keeps a saturating jackpot counter. It sits beside `slot_machine` on the segment wires and feeds the scoring/credit logic.

---
 rtl/reel_readout.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/reel_readout.sv
// Observer for three active-low 7-segment reel buses: decodes digits, detects when every
// reel has stopped, and latches a match result behind valid/ack. Optional: REEL_INVALID_DETECT_EN.

module reel_track #(
  parameter int STABLE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg,
  output logic [3:0] digit,
  output logic       stopped
`ifdef REEL_INVALID_DETECT_EN
  ,
  output logic       bad
`endif
);
  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

  logic [6:0] s;
  logic [7:0] c;

  function automatic logic [3:0] seg_decode(input logic [6:0] p);
    case (p)
      7'b1000000: seg_decode = 4'd0;
      7'b1111001: seg_decode = 4'd1;
      7'b0100100: seg_decode = 4'd2;
      7'b0110000: seg_decode = 4'd3;
      7'b0011001: seg_decode = 4'd4;
      7'b0010010: seg_decode = 4'd5;
      7'b0000010: seg_decode = 4'd6;
      7'b1111000: seg_decode = 4'd7;
      7'b0000000: seg_decode = 4'd8;
      7'b0010000: seg_decode = 4'd9;
      default:    seg_decode = 4'hF;
    endcase
  endfunction

  assign digit   = seg_decode(s);
  assign stopped = (c == STABLE);

`ifdef REEL_INVALID_DETECT_EN
  // Judged on the incoming sample so a bad pattern never accrues stability.
  assign bad = (seg_decode(seg) == 4'hF);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s <= 7'h7F;
      c <= '0;
    end else begin
      s <= seg;
`ifdef REEL_INVALID_DETECT_EN
      if (seg != s || bad) c <= '0;
`else
      if (seg != s) c <= '0;
`endif
      else if (c < STABLE) c <= c + 8'd1;
    end
  end
endmodule

module reel_readout #(
  parameter int STABLE_CYCLES = 16
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic [6:0] i_seg0,
  input  logic [6:0] i_seg1,
  input  logic [6:0] i_seg2,
  input  logic       i_result_ack,
  output logic       o_result_valid,
  output logic [3:0] o_digit0,
  output logic [3:0] o_digit1,
  output logic [3:0] o_digit2,
  output logic [1:0] o_match,
  output logic [7:0] o_win_count,
  output logic       o_fault
);
  localparam int NUM_REELS = 3;

  typedef enum logic [1:0] {ARMED, SPIN, RESULT} state_t;
  typedef struct packed {
    logic [NUM_REELS-1:0][3:0] digit;
    logic [1:0]                match;
  } result_t;

  logic [NUM_REELS-1:0][6:0] seg;
  logic [NUM_REELS-1:0][3:0] digit;
  logic [NUM_REELS-1:0]      stopped;
`ifdef REEL_INVALID_DETECT_EN
  logic [NUM_REELS-1:0]      bad;
`endif

  assign seg = {i_seg2, i_seg1, i_seg0};

  for (genvar i = 0; i < NUM_REELS; i++) begin : g_reel
    reel_track #(.STABLE_CYCLES(STABLE_CYCLES)) u_reel (
      .clk     (i_clock),
      .rst_n   (i_reset),
      .seg     (seg[i]),
      .digit   (digit[i]),
      .stopped (stopped[i])
`ifdef REEL_INVALID_DETECT_EN
      ,
      .bad     (bad[i])
`endif
    );
  end

  // 4'hF never participates in a match.
  logic       eq01, eq02, eq12;
  logic [1:0] match_nxt;
  assign eq01 = (digit[0] == digit[1]) && (digit[0] != 4'hF);
  assign eq02 = (digit[0] == digit[2]) && (digit[0] != 4'hF);
  assign eq12 = (digit[1] == digit[2]) && (digit[1] != 4'hF);
  assign match_nxt = (eq01 && eq12)          ? 2'd2 :
                     (eq01 || eq02 || eq12)  ? 2'd1 : 2'd0;

  state_t  state, state_nxt;
  logic    load, clr;
  result_t res;
  logic    valid;
  logic [7:0] win;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) state <= ARMED;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    clr       = 1'b0;
    case (state)
      ARMED:  if (!(&stopped)) state_nxt = SPIN;
      SPIN:   if (&stopped) begin state_nxt = RESULT; load = 1'b1; end
      RESULT: if (i_result_ack) begin state_nxt = ARMED; clr = 1'b1; end
      default: state_nxt = ARMED;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      res   <= '0;
      valid <= 1'b0;
      win   <= '0;
    end else if (load) begin
      res.digit <= digit;
      res.match <= match_nxt;
      valid     <= 1'b1;
      if (match_nxt == 2'd2 && win != 8'hFF) win <= win + 8'd1;
    end else if (clr) begin
      valid <= 1'b0;
    end
  end

`ifdef REEL_INVALID_DETECT_EN
  logic fault;
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) fault <= 1'b0;
    else if (|bad) fault <= 1'b1;
  end
  assign o_fault = fault;
`else
  assign o_fault = 1'b0;
`endif

  assign o_result_valid = valid;
  assign o_digit0       = res.digit[0];
  assign o_digit1       = res.digit[1];
  assign o_digit2       = res.digit[2];
  assign o_match        = res.match;
  assign o_win_count    = win;
endmodule
